// File: rtl/control_ajustes_pkg.sv
// Shared types and constants for the setpoint adjustment block.
package control_ajustes_pkg;

  // States of the up/down step machine
  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    ESPERA  = 2'd1,
    REPETIR = 2'd2
  } paso_state_e;

  // Encoding of selector_F_I
  localparam logic SEL_F = 1'b0;
  localparam logic SEL_I = 1'b1;

  // Counter width able to hold values 0..n (at least one bit)
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/control_ajustes_if.sv
// Button inputs and setpoint outputs of the adjustment block, bundled.
interface control_ajustes_if;
  import control_ajustes_pkg::*;

  logic       btn_up;
  logic       btn_down;
  logic       btn_sel;
  logic       selector_F_I;
  logic [4:0] Corriente;
  logic [2:0] Frecuencia;
  logic       cambio;

  // Side that presses the buttons and watches the setpoints
  modport master (
    output btn_up, btn_down, btn_sel,
    input  selector_F_I, Corriente, Frecuencia, cambio
  );

  // Side that implements the adjustment logic
  modport slave (
    input  btn_up, btn_down, btn_sel,
    output selector_F_I, Corriente, Frecuencia, cambio
  );

endinterface

// File: rtl/antirrebote.sv
// Button debouncer: 2-flop synchronizer followed by a tick-sampled
// counter that accepts a new level after DEB_SAMPLES agreeing samples.
module antirrebote #(
  parameter int DEB_SAMPLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic dout
);
  import control_ajustes_pkg::*;

  localparam int CNT_W = cnt_width(DEB_SAMPLES);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;

  // Synchronize, then count consecutive ticks that disagree with dout
  always_comb begin
    sync_d = {sync_q[0], din};
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (tick) begin
      if (sync_q[1] != dout_q) begin
        if (cnt_q == CNT_W'(DEB_SAMPLES - 1)) begin
          dout_d = sync_q[1];
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/control_ajustes.sv
// Setpoint adjustment: three debounced buttons drive a selector toggle and
// an up/down step machine with auto-repeat on Corriente / Frecuencia.
module control_ajustes #(
  parameter int TICK_DIV    = 100000,
  parameter int DEB_SAMPLES = 16,
  parameter int REP_DELAY   = 500,
  parameter int REP_RATE    = 100,
  parameter int I_MAX       = 31,
  parameter int F_MAX       = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  output logic       selector_F_I,
  output logic [4:0] Corriente,
  output logic [2:0] Frecuencia,
  output logic       cambio
);
  import control_ajustes_pkg::*;

  localparam int PRE_W    = cnt_width(TICK_DIV - 1);
  localparam int HOLD_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int HOLD_W   = cnt_width(HOLD_MAX);
  // Ticks after reset long enough for a held button to pass the debouncer
  localparam int WIN      = DEB_SAMPLES + 2;
  localparam int WIN_W    = cnt_width(WIN);

  // Saturating +/-1 step; never wraps
  function automatic int unsigned paso_sat(input int unsigned v,
                                           input logic up,
                                           input int unsigned vmax);
    if (up) return (v >= vmax) ? vmax : v + 1;
    else    return (v == 0) ? 0 : v - 1;
  endfunction

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic              tick;
  logic              up_lvl, down_lvl, sel_lvl;
  logic [2:0]        lvl, rise;
  logic [2:0]        prev_q, prev_d;
  logic [2:0]        lock_q, lock_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              win_done;
  paso_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              dir_up_q, dir_up_d;
  logic              step, step_up, held;
  logic              sel_q, sel_d;
  logic [4:0]        corr_q, corr_d;
  logic [2:0]        freq_q, freq_d;
  logic              cambio_q, cambio_d;

  // Free-running prescaler producing a one-cycle sample tick
  always_comb begin
    tick    = (presc_q == PRE_W'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  antirrebote #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_up (
    .clk(clk), .rst(rst), .tick(tick), .din(btn_up), .dout(up_lvl)
  );
  antirrebote #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_down (
    .clk(clk), .rst(rst), .tick(tick), .din(btn_down), .dout(down_lvl)
  );
  antirrebote #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_sel (
    .clk(clk), .rst(rst), .tick(tick), .din(btn_sel), .dout(sel_lvl)
  );

  // Rising edges of debounced levels; a button held through reset stays
  // locked until it is seen released, so it cannot fake a fresh press
  always_comb begin
    lvl      = {sel_lvl, down_lvl, up_lvl};
    prev_d   = lvl;
    win_done = (win_q == WIN_W'(WIN));
    win_d    = (tick && !win_done) ? win_q + 1'b1 : win_q;
    lock_d   = lock_q & ~({3{win_done}} & ~lvl);
    rise     = lvl & ~prev_q & ~lock_q;
  end

  // Step machine: first step on press, then delayed auto-repeat
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    dir_up_d = dir_up_q;
    step     = 1'b0;
    step_up  = dir_up_q;
    held     = dir_up_q ? up_lvl : down_lvl;
    unique case (state_q)
      REPOSO: begin
        if (rise[0] && !down_lvl) begin
          step     = 1'b1;
          step_up  = 1'b1;
          dir_up_d = 1'b1;
          hold_d   = '0;
          state_d  = ESPERA;
        end else if (rise[1] && !up_lvl) begin
          step     = 1'b1;
          step_up  = 1'b0;
          dir_up_d = 1'b0;
          hold_d   = '0;
          state_d  = ESPERA;
        end
      end
      ESPERA: begin
        if (!held || (up_lvl && down_lvl)) begin
          hold_d  = '0;
          state_d = REPOSO;
        end else if (tick) begin
          if (hold_q == HOLD_W'(REP_DELAY - 1)) begin
            step    = 1'b1;
            hold_d  = '0;
            state_d = REPETIR;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      REPETIR: begin
        if (!held || (up_lvl && down_lvl)) begin
          hold_d  = '0;
          state_d = REPOSO;
        end else if (tick) begin
          if (hold_q == HOLD_W'(REP_RATE - 1)) begin
            step   = 1'b1;
            hold_d = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: begin
        hold_d  = '0;
        state_d = REPOSO;
      end
    endcase
  end

  // Setpoint update; the step uses the selection before any same-cycle toggle
  always_comb begin
    sel_d  = sel_q ^ rise[2];
    corr_d = corr_q;
    freq_d = freq_q;
    if (step) begin
      if (sel_q == SEL_I)
        corr_d = 5'(paso_sat(32'(corr_q), step_up, 32'(I_MAX)));
      else
        freq_d = 3'(paso_sat(32'(freq_q), step_up, 32'(F_MAX)));
    end
    cambio_d = (corr_d != corr_q) || (freq_d != freq_q) || (sel_d != sel_q);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      prev_q   <= '0;
      lock_q   <= '1;
      win_q    <= '0;
      state_q  <= REPOSO;
      hold_q   <= '0;
      dir_up_q <= 1'b0;
      sel_q    <= SEL_F;
      corr_q   <= '0;
      freq_q   <= '0;
      cambio_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      prev_q   <= prev_d;
      lock_q   <= lock_d;
      win_q    <= win_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      dir_up_q <= dir_up_d;
      sel_q    <= sel_d;
      corr_q   <= corr_d;
      freq_q   <= freq_d;
      cambio_q <= cambio_d;
    end
  end

  assign selector_F_I = sel_q;
  assign Corriente    = corr_q;
  assign Frecuencia   = freq_q;
  assign cambio       = cambio_q;

endmodule

// File: doc/control_ajustes.md
CONTROL_AJUSTES -- requirements
Module: control_ajustes

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, meaning clk cycles per sample tick (1 ms at 100 MHz).
REQ-002 SHALL have parameter DEB_SAMPLES, default 16, meaning consecutive equal tick samples needed to accept a button level.
REQ-003 SHALL have parameter REP_DELAY, default 500, meaning ticks a button is held before auto-repeat starts.
REQ-004 SHALL have parameter REP_RATE, default 100, meaning ticks between auto-repeat steps.
REQ-005 SHALL have parameter I_MAX, default 31, meaning upper limit of Corriente.
REQ-006 SHALL have parameter F_MAX, default 7, meaning upper limit of Frecuencia.
REQ-007 SHALL have port clk, input, 1, the single system clock.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port btn_up, input, 1, raw asynchronous increment button (high = pressed).
REQ-010 SHALL have port btn_down, input, 1, raw asynchronous decrement button.
REQ-011 SHALL have port btn_sel, input, 1, raw asynchronous selector button.
REQ-012 SHALL have port selector_F_I, output, 1, 0 = Frecuencia selected, 1 = Corriente selected.
REQ-013 SHALL have port Corriente, output, 5, current setpoint.
REQ-014 SHALL have port Frecuencia, output, 3, frequency setpoint.
REQ-015 SHALL have port cambio, output, 1, one-cycle pulse on any change of Corriente, Frecuencia or selector_F_I.

Function
REQ-016 SHALL pass each raw button through a 2-flop synchronizer before any other use.
REQ-017 SHALL generate a one-cycle tick every TICK_DIV clk cycles from a free-running prescaler.
REQ-018 SHALL change a debounced level only after DEB_SAMPLES consecutive ticks sample the synchronized input at the new value.
REQ-019 SHALL toggle selector_F_I exactly once per debounced rising edge of btn_sel; holding btn_sel does not repeat.
REQ-020 SHALL run one step FSM with states REPOSO, ESPERA, REPETIR, driven by debounced up/down levels.
REQ-021 In REPOSO, exactly one of up/down newly high SHALL issue one step in that direction, clear the hold counter and go to ESPERA.
REQ-022 In ESPERA, the hold counter SHALL count ticks; at REP_DELAY it issues one step, clears the counter and goes to REPETIR.
REQ-023 In REPETIR, it SHALL issue one step every REP_RATE ticks while the same button stays high.
REQ-024 From ESPERA or REPETIR, release of the held button, or both buttons high, SHALL return the FSM to REPOSO with no step.
REQ-025 Up and down both high in REPOSO SHALL issue no step and keep the FSM in REPOSO.
REQ-026 A step SHALL modify only the selected parameter: Corriente when selector_F_I = 1, else Frecuencia.
REQ-027 Increments SHALL saturate at I_MAX or F_MAX, decrements SHALL saturate at 0, and values SHALL never wrap.
REQ-028 A saturated step that leaves the value unchanged SHALL NOT pulse cambio.
REQ-029 A step SHALL update the register one clk cycle after the debounced edge or terminal tick, with cambio asserted in the same cycle as the new value.
REQ-030 A selector toggle coinciding with a step in the same cycle SHALL apply the step to the pre-toggle selection.

Reset
REQ-031 While rst = 1 at a clk edge, Corriente = 0, Frecuencia = 0, selector_F_I = 0 and cambio = 0.
REQ-032 Reset SHALL also put the FSM in REPOSO, clear the prescaler, hold and debounce counters, and set debounced levels and synchronizers to 0.
REQ-033 Reset asserted while a button is held SHALL require a fresh debounced rising edge before the next step.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding (REPOSO/ESPERA/REPETIR) and the selector encoding constants SEL_F = 0, SEL_I = 1.
REQ-035 Debounce SHALL be the sub-module antirrebote (clk, rst, tick, din, dout), containing synchronizer and sample counter, instantiated three times.
REQ-036 Outputs SHALL connect directly to the display-control inputs Corriente, Frecuencia and selector_F_I with no glue logic.

Verification (sim params TICK_DIV=4, DEB_SAMPLES=3, REP_DELAY=8, REP_RATE=4)
REQ-037 Reset then idle for 200 cycles -> outputs 0, with no cambio pulse.
REQ-038 Glitch btn_up high for 2 ticks, then release -> no change; a clean 5-tick press with selector 0 -> Frecuencia 0->1 and a single cambio pulse.
REQ-039 With Frecuencia at 6, hold btn_up for 40 ticks -> value goes to 7, then stays at 7 with no further cambio pulses.
REQ-040 Press btn_sel, then hold btn_down with Corriente at 3 -> selector_F_I = 1 and Corriente steps 3, 2, 1, 0 at debounce, +8 and +12 ticks, then holds at 0.
REQ-041 Press btn_up and btn_down simultaneously -> no step and the FSM stays in REPOSO.
REQ-042 Assert rst mid-repeat with btn_up still held -> all outputs 0, and no step until btn_up is released and pressed again.
